// File: rtl/gpio_arbiter_if.sv
// Bus bundle shared by the two masters, the arbiter and the GPIO block.
// The arbiter uses the slave view; the master side (masters + GPIO block) uses master.
interface gpio_arbiter_if #(
    parameter int DW = 32,
    parameter int AW = 2
);
    logic          req0;
    logic          req1;
    logic          we0;
    logic          we1;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    logic [DW-1:0] wd0;
    logic [DW-1:0] wd1;
    logic          done0;
    logic          done1;
    logic [DW-1:0] rd0;
    logic [DW-1:0] rd1;
    logic          err1;
    logic          gpio_we;
    logic [AW-1:0] gpio_a;
    logic [DW-1:0] gpio_wd;
    logic [DW-1:0] gpio_rd;

    modport slave (
        input  req0, req1, we0, we1, a0, a1, wd0, wd1, gpio_rd,
        output done0, done1, rd0, rd1, err1, gpio_we, gpio_a, gpio_wd
    );

    modport master (
        output req0, req1, we0, we1, a0, a1, wd0, wd1, gpio_rd,
        input  done0, done1, rd0, rd1, err1, gpio_we, gpio_a, gpio_wd
    );
endinterface

// File: rtl/gpio_arbiter.sv
// Two-master round-robin arbiter in front of the GPIO register port.
// Define GPIO_ARB_WPROT_EN to block master 1 writes to gpo1 and flag them on err1.
//
// state | meaning
// IDLE  | no transaction in flight, arbitrating
// SERVE | latched command driven onto the GPIO port, read data captured
// RESP  | done strobe to served master, re-arbitrating with its req masked
module gpio_arbiter #(
    parameter int DW = 32,
    parameter int AW = 2
) (
    input logic          clk,
    input logic          rst,
    gpio_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          last_q, last_d;
    logic          id_q, id_d;
    logic          we_q, we_d;
    logic [AW-1:0] a_q, a_d;
    logic [DW-1:0] wd_q, wd_d;
    logic          done0_q, done0_d;
    logic          done1_q, done1_d;
    logic          err1_q, err1_d;
    logic [DW-1:0] rd0_q, rd0_d;
    logic [DW-1:0] rd1_q, rd1_d;

    logic          r0, r1, grant, win, blocked;

`ifdef GPIO_ARB_WPROT_EN
    assign blocked = id_q && we_q && (a_q == AW'(2));
`else
    assign blocked = 1'b0;
`endif

    // The master just served still holds req during RESP, so it is masked there.
    always_comb begin
        r0    = bus.req0 && !((state_q == RESP) && !id_q);
        r1    = bus.req1 && !((state_q == RESP) && id_q);
        grant = r0 || r1;
        win   = (r0 && r1) ? ~last_q : r1;
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        id_d    = id_q;
        we_d    = we_q;
        a_d     = a_q;
        wd_d    = wd_q;
        done0_d = 1'b0;
        done1_d = 1'b0;
        err1_d  = 1'b0;
        rd0_d   = rd0_q;
        rd1_d   = rd1_q;
        case (state_q)
            IDLE, RESP: begin
                if (grant) begin
                    state_d = SERVE;
                    id_d    = win;
                    we_d    = win ? bus.we1 : bus.we0;
                    a_d     = win ? bus.a1  : bus.a0;
                    wd_d    = win ? bus.wd1 : bus.wd0;
                end else begin
                    state_d = IDLE;
                end
            end
            SERVE: begin
                state_d = RESP;
                last_d  = id_q;
                err1_d  = blocked;
                if (id_q) begin
                    done1_d = 1'b1;
                    if (!we_q) rd1_d = bus.gpio_rd;
                end else begin
                    done0_d = 1'b1;
                    if (!we_q) rd0_d = bus.gpio_rd;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            id_q    <= 1'b0;
            we_q    <= 1'b0;
            a_q     <= '0;
            wd_q    <= '0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            err1_q  <= 1'b0;
            rd0_q   <= '0;
            rd1_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            we_q    <= we_d;
            a_q     <= a_d;
            wd_q    <= wd_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            err1_q  <= err1_d;
            rd0_q   <= rd0_d;
            rd1_q   <= rd1_d;
        end
    end

    // Address/data only change at grant, so the latch doubles as the hold value.
    assign bus.gpio_we = (state_q == SERVE) && we_q && !blocked;
    assign bus.gpio_a  = a_q;
    assign bus.gpio_wd = wd_q;
    assign bus.done0   = done0_q;
    assign bus.done1   = done1_q;
    assign bus.rd0     = rd0_q;
    assign bus.rd1     = rd1_q;
    assign bus.err1    = err1_q;

endmodule
